// File: rtl/if_pkg.sv
// Shared constants for the non-blocking fetch stage: IF->ID bus layout, reset vector
// and the width helper used for the in-flight request counters.
package if_pkg;

  localparam int          IF_TO_ID_BUS_W   = 65;
  localparam int          ADEF_BIT         = 64;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH need not be a power of two.
// A full FIFO accepts a push in the same cycle as a pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] ptr);
    return (int'(ptr) == DEPTH - 1) ? '0 : ptr + AW'(1);
  endfunction

  assign full    = (int'(count) == DEPTH);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // NOTE: storage is not reset; count/empty guard every read, so reset only costs area here.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_stage_nb.sv
// Non-blocking instruction fetch stage: issues inst_sram requests under a credit rule,
// tracks in-flight requests and drops responses that belong to cancelled fetches.
module if_stage_nb
  import if_pkg::*;
#(
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      inst_sram_req,
  output logic [31:0]               inst_sram_addr,
  input  logic                      inst_sram_addr_ok,
  input  logic                      inst_sram_data_ok,
  input  logic [31:0]               inst_sram_rdata,
  input  logic                      redir_valid,
  input  logic [31:0]               redir_target,
  input  logic                      br_stall,
  input  logic                      id_allowin,
  output logic                      if_to_id_valid,
  output logic [IF_TO_ID_BUS_W-1:0] if_to_id_bus
);

  localparam int CNT_W   = cnt_w(MAX_OUTSTANDING);
  localparam int IBUF_CW = $clog2(IBUF_DEPTH + 1);

  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_next;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] discard_cnt;
  logic [CNT_W-1:0] discard_cnt_next;

  logic             handshake;
  logic             rsp_keep;
  logic             rsp_drop;

  logic [31:0]      pc_q_head;
  logic [CNT_W-1:0] pc_q_count;
  logic             pc_q_full;
  logic             pc_q_empty;

  logic [IF_TO_ID_BUS_W-1:0] ibuf_wdata;
  logic [IF_TO_ID_BUS_W-1:0] ibuf_head;
  logic [IBUF_CW-1:0]        ibuf_count;
  logic                      ibuf_push;
  logic                      ibuf_pop;
  logic                      ibuf_full;
  logic                      ibuf_empty;

  // Credit rule: every accepted request has a reserved ibuf slot for its response.
  assign inst_sram_req = ~reset & ~br_stall & ~redir_valid
                       & (int'(outstanding) < MAX_OUTSTANDING)
                       & (int'(outstanding) + int'(ibuf_count) < IBUF_DEPTH);
  assign inst_sram_addr = fetch_pc;

  assign handshake = inst_sram_req & inst_sram_addr_ok;
  assign rsp_drop  = inst_sram_data_ok & (discard_cnt != '0);
  assign rsp_keep  = inst_sram_data_ok & (discard_cnt == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    fetch_pc_next    = fetch_pc;
    outstanding_next = outstanding + CNT_W'(handshake) - CNT_W'(inst_sram_data_ok);
    discard_cnt_next = discard_cnt - CNT_W'(rsp_drop);
    if (redir_valid) begin
      fetch_pc_next    = redir_target;
      // Stale responses are a subset of those in flight: after a flush all of them are stale,
      // less the one returning this cycle.
      discard_cnt_next = outstanding - CNT_W'(inst_sram_data_ok);
    end else if (handshake) begin
      fetch_pc_next = fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      discard_cnt <= discard_cnt_next;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_q (
    .clk   (clk),
    .reset (reset),
    .push  (handshake),
    .pop   (inst_sram_data_ok),
    .flush (1'b0),
    .wdata (fetch_pc),
    .rdata (pc_q_head),
    .count (pc_q_count),
    .full  (pc_q_full),
    .empty (pc_q_empty)
  );

  always_comb begin
    ibuf_wdata           = {1'b0, inst_sram_rdata, pc_q_head};
    ibuf_wdata[ADEF_BIT] = (pc_q_head[1:0] != 2'b00);
  end

  assign ibuf_push = rsp_keep & ~redir_valid;
  assign ibuf_pop  = if_to_id_valid & id_allowin;

  sync_fifo #(
    .WIDTH (IF_TO_ID_BUS_W),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .push  (ibuf_push),
    .pop   (ibuf_pop),
    .flush (redir_valid),
    .wdata (ibuf_wdata),
    .rdata (ibuf_head),
    .count (ibuf_count),
    .full  (ibuf_full),
    .empty (ibuf_empty)
  );

  assign if_to_id_valid = ~reset & ~redir_valid & ~ibuf_empty;
  assign if_to_id_bus   = if_to_id_valid ? ibuf_head : '0;

  logic unused_status;
  assign unused_status = ^{pc_q_count, pc_q_full, pc_q_empty, ibuf_full};

endmodule
